// File: rtl/module_cla_multiword_adder.sv
// Multi-cycle wide adder: one CLA_WIDTH-bit carry-look-ahead slice is reused per chunk, LSB chunk first.
// Optional signed-overflow output is enabled by defining CLA_MULTIWORD_OVERFLOW_EN.
module module_cla_multiword_adder #(
    parameter int CLA_WIDTH  = 8,
    parameter int NUM_CHUNKS = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            valid_i,
    output logic                            ready_o,
    input  logic [CLA_WIDTH*NUM_CHUNKS-1:0] a_i,
    input  logic [CLA_WIDTH*NUM_CHUNKS-1:0] b_i,
    input  logic                            carry_i,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic [CLA_WIDTH*NUM_CHUNKS-1:0] sum_o,
    output logic                            carry_o
`ifdef CLA_MULTIWORD_OVERFLOW_EN
    ,
    output logic                            overflow_o
`endif
);

    localparam int W  = CLA_WIDTH * NUM_CHUNKS;
    localparam int CW = $clog2(NUM_CHUNKS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [W-1:0]         r_a;
    logic [W-1:0]         r_b;
    logic [W-1:0]         r_sum;
    logic                 r_carry;
    logic [CW-1:0]        r_cnt;
    logic                 w_last;
    logic [CLA_WIDTH-1:0] w_a_chunk;
    logic [CLA_WIDTH-1:0] w_b_chunk;
    logic [CLA_WIDTH-1:0] w_g;
    logic [CLA_WIDTH-1:0] w_p;
    logic [CLA_WIDTH:0]   w_c;
    logic [CLA_WIDTH-1:0] w_s;

    assign w_last = (r_cnt == CW'(NUM_CHUNKS - 1));

    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int k = 0; k < NUM_CHUNKS; k++) begin
            if (r_cnt == CW'(k)) begin
                w_a_chunk = r_a[k*CLA_WIDTH +: CLA_WIDTH];
                w_b_chunk = r_b[k*CLA_WIDTH +: CLA_WIDTH];
            end
        end
    end

    // Look-ahead carries: c[i+1] = OR over j<=i of g[j] & p[i:j+1], plus p[i:0] & cin.
    assign w_g    = w_a_chunk & w_b_chunk;
    assign w_p    = w_a_chunk ^ w_b_chunk;
    assign w_c[0] = r_carry;

    genvar gi, gj;
    generate
        for (gi = 0; gi < CLA_WIDTH; gi++) begin : g_carry
            logic [gi+1:0] w_terms;
            assign w_terms[0] = (&w_p[gi:0]) & r_carry;
            for (gj = 0; gj <= gi; gj++) begin : g_term
                if (gj == gi) begin : g_gen
                    assign w_terms[gj+1] = w_g[gj];
                end else begin : g_prop
                    assign w_terms[gj+1] = w_g[gj] & (&w_p[gi:gj+1]);
                end
            end
            assign w_c[gi+1] = |w_terms;
        end
    endgenerate

    assign w_s = w_p ^ w_c[CLA_WIDTH-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (valid_i) w_state_next = ADD;
            ADD:     if (w_last)  w_state_next = DONE;
            DONE:    if (ready_i) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == IDLE && valid_i) begin
            r_a     <= a_i;
            r_b     <= b_i;
            r_carry <= carry_i;
            r_sum   <= '0;
            r_cnt   <= '0;
        end else if (r_state == ADD) begin
            for (int k = 0; k < NUM_CHUNKS; k++) begin
                if (r_cnt == CW'(k)) r_sum[k*CLA_WIDTH +: CLA_WIDTH] <= w_s;
            end
            r_carry <= w_c[CLA_WIDTH];
            r_cnt   <= r_cnt + CW'(1);
        end
    end

`ifdef CLA_MULTIWORD_OVERFLOW_EN
    logic r_ovf;

    // Evaluated only on the top chunk, where w_s[CLA_WIDTH-1] is the result MSB.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ovf <= 1'b0;
        end else if (r_state == IDLE && valid_i) begin
            r_ovf <= 1'b0;
        end else if (r_state == ADD && w_last) begin
            r_ovf <= (r_a[W-1] == r_b[W-1]) && (w_s[CLA_WIDTH-1] != r_a[W-1]);
        end
    end

    assign overflow_o = r_ovf;
`endif

    assign ready_o = (r_state == IDLE);
    assign valid_o = (r_state == DONE);
    assign sum_o   = r_sum;
    assign carry_o = r_carry;

endmodule

// File: tb/tb_module_cla_multiword_adder.sv
// Self-checking bench for module_cla_multiword_adder: directed cases plus random operands vs. an arithmetic model.
// Overflow checks are compiled in when CLA_MULTIWORD_OVERFLOW_EN is defined.
module tb_module_cla_multiword_adder;

    localparam int CLA_WIDTH  = 8;
    localparam int NUM_CHUNKS = 4;
    localparam int W          = CLA_WIDTH * NUM_CHUNKS;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         valid_i = 1'b0;
    logic         ready_o;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         carry_i = 1'b0;
    logic         valid_o;
    logic         ready_i = 1'b0;
    logic [W-1:0] sum_o;
    logic         carry_o;
`ifdef CLA_MULTIWORD_OVERFLOW_EN
    logic         overflow_o;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    module_cla_multiword_adder #(
        .CLA_WIDTH (CLA_WIDTH),
        .NUM_CHUNKS(NUM_CHUNKS)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .a_i       (a_i),
        .b_i       (b_i),
        .carry_i   (carry_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .sum_o     (sum_o),
        .carry_o   (carry_o)
`ifdef CLA_MULTIWORD_OVERFLOW_EN
        ,
        .overflow_o(overflow_o)
`endif
    );

    initial forever #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Full transaction: accept, latency check, optional backpressure, result check, handshake.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input int stall);
        logic [W:0]   full;
        logic [W-1:0] exp_sum;
        logic         exp_c;
        logic         exp_ovf;
        full    = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        exp_sum = full[W-1:0];
        exp_c   = full[W];
        exp_ovf = (a[W-1] == b[W-1]) && (exp_sum[W-1] != a[W-1]);

        check("ready_before_accept", 64'(ready_o), 64'd1);
        a_i = a; b_i = b; carry_i = cin; valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        a_i = $urandom; b_i = $urandom; carry_i = 1'($urandom_range(0, 1));
        check("ready_after_accept", 64'(ready_o), 64'd0);
        for (int k = 1; k <= NUM_CHUNKS; k++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            check($sformatf("valid_latency_k%0d", k), 64'(valid_o), 64'(k == NUM_CHUNKS));
        end
        check("sum", 64'(sum_o), 64'(exp_sum));
        check("carry", 64'(carry_o), 64'(exp_c));
`ifdef CLA_MULTIWORD_OVERFLOW_EN
        check("overflow", 64'(overflow_o), 64'(exp_ovf));
`endif
        for (int k = 0; k < stall; k++) begin
            a_i = $urandom; b_i = $urandom; valid_i = 1'b1;
            @(posedge clk_i);
            @(negedge clk_i);
            check("stall_valid", 64'(valid_o), 64'd1);
            check("stall_ready", 64'(ready_o), 64'd0);
            check("stall_sum", 64'(sum_o), 64'(exp_sum));
            check("stall_carry", 64'(carry_o), 64'(exp_c));
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        ready_i = 1'b0;
        check("valid_after_handshake", 64'(valid_o), 64'd0);
        check("ready_after_handshake", 64'(ready_o), 64'd1);
        check("sum_held_after_handshake", 64'(sum_o), 64'(exp_sum));
        $display("op a=0x%08h b=0x%08h cin=%0d -> sum=0x%08h carry=%0d (ref 0x%08h %0d ovf %0d)",
                 a, b, cin, sum_o, carry_o, exp_sum, exp_c, exp_ovf);
    endtask

    initial begin
        // Power-on reset state
        #12;
        check("reset_ready", 64'(ready_o), 64'd1);
        check("reset_valid", 64'(valid_o), 64'd0);
        check("reset_sum", 64'(sum_o), 64'd0);
        check("reset_carry", 64'(carry_o), 64'd0);
`ifdef CLA_MULTIWORD_OVERFLOW_EN
        check("reset_overflow", 64'(overflow_o), 64'd0);
`endif
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        run_op(32'h0000_0001, 32'h0000_0002, 1'b0, 0);
        run_op(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 0);
        run_op(32'h0000_00FF, 32'h0000_0000, 1'b1, 0);
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0);
        run_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 5);

        // Asynchronous reset two ADD cycles into an operation
        check("ready_before_abort", 64'(ready_o), 64'd1);
        a_i = 32'h1234_5678; b_i = 32'h1111_1111; carry_i = 1'b0; valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        check("abort_ready", 64'(ready_o), 64'd1);
        check("abort_valid", 64'(valid_o), 64'd0);
        check("abort_sum", 64'(sum_o), 64'd0);
        check("abort_carry", 64'(carry_o), 64'd0);
        $display("async reset mid-op -> ready=%0d valid=%0d sum=0x%08h", ready_o, valid_o, sum_o);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 0);

        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
